// File: rtl/pio_pkg.sv
// Shared definitions for the input PIO slave: register map,
// edge-mode encodings and a constant-friendly clog2.
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pio_bit_debounce.sv
// One input bit: synchroniser chain, persistence counter, stable
// value and a single-cycle event when stable moves the selected way.
module pio_bit_debounce
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_MODE       = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable_o,
    output logic event_o
);

    localparam int unsigned D  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int unsigned CW = clog2(D) + 1;
    localparam logic [CW-1:0] D_LAST = CW'(D - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   stable_q;
    logic                   stable_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   sync_out;
    logic                   want;
    logic                   event_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        want = sync_out;
        case (EDGE_MODE)
            EDGE_FALL: want = ~sync_out;
            EDGE_ANY:  want = 1'b1;
            default:   want = sync_out;
        endcase
    end

    // The edge that would complete the run accepts the value instead
    // of counting, so acceptance lands exactly D edges after the change.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        stable_d = stable_q;
        cnt_d    = '0;
        event_d  = 1'b0;
        if (sync_out != stable_q) begin
            if (cnt_q == D_LAST) begin
                stable_d = sync_out;
                event_d  = want;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign event_o  = event_d;

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: debounced live value, interrupt mask and
// write-1-to-clear edge capture driving a level interrupt.
module pio_in_edge_capture
    import pio_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] clr;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             unused_ok;

    assign unused_ok = &{1'b0, read, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_bit_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_MODE       (EDGE_MODE)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .din      (in_port[i]),
            .stable_o (stable[i]),
            .event_o  (evt[i])
        );
    end

    // A new event outranks a software clear on the same bit.
    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        if (write && (address == PIO_ADDR_EDGE)) begin
            clr = writedata[WIDTH-1:0];
        end
        if (write && (address == PIO_ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~clr) | evt;
    end

    always_comb begin
        readdata_d = '0;
        unique case (address)
            PIO_ADDR_DATA: readdata_d = 32'(stable);
            PIO_ADDR_RSVD: readdata_d = '0;
            PIO_ADDR_MASK: readdata_d = 32'(mask_q);
            PIO_ADDR_EDGE: readdata_d = 32'(cap_q);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Scoreboard bench: rising-edge and any-edge instances share all
// inputs and are compared against a history-window reference model.
module tb_pio_in_edge_capture;

    localparam int W  = 10;
    localparam int SS = 2;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd0;
    logic [31:0]   rd2;
    logic          irq0;
    logic          irq2;

    always #5 clk = ~clk;

    pio_in_edge_capture #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(rd0),
        .irq(irq0), .in_port(in_port)
    );

    pio_in_edge_capture #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2)
    ) dut2 (
        .clk(clk), .reset(reset), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(rd2),
        .irq(irq2), .in_port(in_port)
    );

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd2;
        logic        i0;
        logic        i2;
        int          n;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable, m_mask, m_cap0, m_cap2;
    logic [31:0]  m_rd0, m_rd2;
    logic [W-1:0] cin;
    int           edge_n = 0;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_stable = '0;
        m_mask   = '0;
        m_cap0   = '0;
        m_cap2   = '0;
        m_rd0    = '0;
        m_rd2    = '0;
        foreach (hist[i]) hist[i] = '0;
    endtask

    // A bit flips once the synchronised input has shown the opposite
    // value on each of the last DC edges; the synchronised value seen
    // at edge k is the input that was present SS edges earlier.
    task automatic model_edge(input logic rst, input logic [1:0] a,
                              input logic w, input logic [31:0] wd,
                              input logic [W-1:0] inp);
        logic [W-1:0] ns, rise, fall, clr;
        bit ok;
        edge_n++;
        if (rst) begin
            model_reset();
            hist.push_back('0);
        end else begin
            hist.push_back(inp);
            ns = m_stable;
            for (int b = 0; b < W; b++) begin
                ok = 1'b1;
                for (int j = SS; j < SS + DC; j++) begin
                    if (hist[hist.size() - 1 - j][b] == m_stable[b]) ok = 1'b0;
                end
                if (ok) ns[b] = ~m_stable[b];
            end
            rise = ns & ~m_stable;
            fall = ~ns & m_stable;
            case (a)
                2'd0: begin m_rd0 = 32'(m_stable); m_rd2 = 32'(m_stable); end
                2'd1: begin m_rd0 = '0; m_rd2 = '0; end
                2'd2: begin m_rd0 = 32'(m_mask); m_rd2 = 32'(m_mask); end
                default: begin m_rd0 = 32'(m_cap0); m_rd2 = 32'(m_cap2); end
            endcase
            clr = (w && a == 2'd3) ? wd[W-1:0] : '0;
            m_cap0 = (m_cap0 & ~clr) | rise;
            m_cap2 = (m_cap2 & ~clr) | rise | fall;
            if (w && a == 2'd2) m_mask = wd[W-1:0];
            m_stable = ns;
        end
        while (hist.size() > 32) void'(hist.pop_front());
        sbq.push_back('{m_rd0, m_rd2, |(m_cap0 & m_mask),
                        |(m_cap2 & m_mask), edge_n});
    endtask

    task automatic cyc(input logic rst, input logic [1:0] a, input logic w,
                       input logic [31:0] wd, input logic [W-1:0] inp);
        @(negedge clk);
        reset     = rst;
        address   = a;
        write     = w;
        writedata = wd;
        in_port   = inp;
        read      = ~w & 1'($urandom_range(0, 1));
        model_edge(rst, a, w, wd, inp);
        if (rst) begin
            #1;
            check("rst_now_rd0", rd0, 32'd0);
            check("rst_now_rd2", rd2, 32'd0);
            check("rst_now_irq0", 32'(irq0), 32'd0);
            check("rst_now_irq2", 32'(irq2), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 32'd0, cin);
    endtask

    task automatic look();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check($sformatf("sb_rd0 e%0d", e.n), rd0, e.rd0);
                check($sformatf("sb_rd2 e%0d", e.n), rd2, e.rd2);
                check($sformatf("sb_irq0 e%0d", e.n), 32'(irq0), 32'(e.i0));
                check($sformatf("sb_irq2 e%0d", e.n), 32'(irq2), 32'(e.i2));
            end
        end
    end

    initial begin : driver
        logic       r, w;
        logic [1:0] a;
        for (int i = 0; i < 8; i++) hist.push_back('0);
        model_reset();
        cin = '0;
        cyc(1'b1, 2'd0, 1'b0, 32'd0, cin);
        cyc(1'b1, 2'd0, 1'b0, 32'd0, cin);
        idle(8);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'(i), 1'b0, 32'd0, cin);
            look();
            check($sformatf("reset_reg%0d", i), rd0, 32'd0);
            check("reset_irq", 32'(irq0), 32'd0);
        end

        cin = 10'h005;
        idle(5);
        cyc(1'b0, 2'd0, 1'b0, 32'd0, cin);
        look();
        check("data_edge6", rd0, 32'h0);
        cyc(1'b0, 2'd0, 1'b0, 32'd0, cin);
        look();
        check("data_edge7", rd0, 32'h005);
        cyc(1'b0, 2'd3, 1'b0, 32'd0, cin);
        look();
        check("cap_005", rd0, 32'h005);
        check("irq_mask0", 32'(irq0), 32'd0);
        cyc(1'b0, 2'd2, 1'b1, 32'h004, cin);
        look();
        check("irq_mask4", 32'(irq0), 32'd1);
        cyc(1'b0, 2'd3, 1'b1, 32'h001, cin);
        cyc(1'b0, 2'd3, 1'b0, 32'd0, cin);
        look();
        check("cap_clr1", rd0, 32'h004);
        check("irq_after_clr1", 32'(irq0), 32'd1);
        cyc(1'b0, 2'd3, 1'b1, 32'h004, cin);
        cyc(1'b0, 2'd3, 1'b0, 32'd0, cin);
        look();
        check("cap_clr4", rd0, 32'h0);
        check("irq_after_clr4", 32'(irq0), 32'd0);

        for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 1'b0, 32'd0, cin | 10'h008);
        idle(8);
        cyc(1'b0, 2'd0, 1'b0, 32'd0, cin);
        look();
        check("glitch_data", rd0, 32'h005);
        cyc(1'b0, 2'd3, 1'b0, 32'd0, cin);
        look();
        check("glitch_cap", rd0, 32'h0);

        cin = 10'h004;
        idle(8);
        cyc(1'b0, 2'd3, 1'b1, 32'hFFFF_FFFF, cin);
        cin = 10'h005;
        idle(5);
        cyc(1'b0, 2'd3, 1'b1, 32'h001, cin);
        cyc(1'b0, 2'd3, 1'b0, 32'd0, cin);
        look();
        check("set_wins0", rd0, 32'h001);
        check("set_wins2", rd2, 32'h001);

        cyc(1'b0, 2'd3, 1'b1, 32'hFFFF_FFFF, cin);
        cin[9] = 1'b1;
        idle(8);
        cyc(1'b0, 2'd3, 1'b0, 32'd0, cin);
        look();
        check("b9_rise_any", rd2, 32'h200);
        check("b9_rise_rise", rd0, 32'h200);
        cyc(1'b0, 2'd3, 1'b1, 32'h200, cin);
        cin[9] = 1'b0;
        idle(8);
        cyc(1'b0, 2'd3, 1'b0, 32'd0, cin);
        look();
        check("b9_fall_any", rd2, 32'h200);
        check("b9_fall_rise", rd0, 32'h0);

        cin[9] = 1'b1;
        idle(3);
        cyc(1'b1, 2'd3, 1'b0, 32'd0, cin);
        cin = '0;
        cyc(1'b1, 2'd3, 1'b0, 32'd0, cin);
        idle(10);
        cyc(1'b0, 2'd3, 1'b0, 32'd0, cin);
        look();
        check("rst_mid_cap0", rd0, 32'h0);
        check("rst_mid_cap2", rd2, 32'h0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0)
                cin = cin ^ (10'd1 << $urandom_range(0, W - 1));
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 3) == 0);
            a = 2'($urandom_range(0, 3));
            cyc(r, a, w, $urandom, cin);
        end
        idle(2);
        look();
        #2;
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
